// File: rtl/rnn_cell_param.sv
// rnn_cell_param: recurrent cell h_t = act(W_hh*h_(t-1) + W_ih*x_t + b_ih + b_hh) over T timesteps.
// Weights, biases, T and the h outputs all share one single-port memory addressed by msel/maddr.
module rnn_cell_param #(
    parameter int HID     = 64,
    parameter int IN_BITS = 32,
    parameter int DW      = 20,
    parameter int FW      = 16,
    parameter int TW      = 11,
    parameter int MAW     =
        ((TW + $clog2(HID)) >= (2 * $clog2(HID)) &&
         (TW + $clog2(HID)) >= ($clog2(HID) + $clog2(IN_BITS))) ? (TW + $clog2(HID)) :
        ((2 * $clog2(HID)) >= ($clog2(HID) + $clog2(IN_BITS))) ? (2 * $clog2(HID)) :
        ($clog2(HID) + $clog2(IN_BITS))
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic [1:0]         act_mode,
    input  logic [IN_BITS-1:0] idata,
    input  logic [DW-1:0]      mdata_r,
    output logic               busy,
    output logic               i_en,
    output logic               mce,
    output logic [2:0]         msel,
    output logic [MAW-1:0]     maddr,
    output logic [DW-1:0]      mdata_w,
    output logic [3:0]         o_dbg_state
);
    localparam int HW = $clog2(HID);
    localparam int KW = $clog2(IN_BITS);
    localparam int AW = 2 * DW + HW + KW + 2;

    localparam logic signed [AW-1:0] C_ONE  = AW'(1) << FW;
    localparam logic signed [AW-1:0] C_HALF = AW'(1) << (FW - 1);
    localparam logic signed [AW-1:0] C_MAXD = (AW'(1) << (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] C_MIND = -C_MAXD - AW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_T, S_GET_X, S_BIAS, S_WIH, S_WHH, S_WRITE, S_SWAP, S_DONE
    } state_t;

    state_t                  r_state, w_next;
    logic                    r_ph;
    logic [1:0]              r_mode;
    logic [TW-1:0]           r_tcnt, r_t;
    logic [HW-1:0]           r_j, r_i, r_pi;
    logic [IN_BITS-1:0]      r_x, r_xrem, w_xrem_nx;
    logic [KW-1:0]           w_k;
    logic                    r_pv, r_pmul;
    logic signed [AW-1:0]    r_acc, w_term, w_rnd, w_lo, w_hi, w_sat;
    logic signed [DW-1:0]    r_h_cur [HID];
    logic signed [DW-1:0]    r_h_nxt [HID];
    logic signed [DW-1:0]    w_md, w_r_act;
    logic signed [2*DW-1:0]  w_prod;

    assign o_dbg_state = r_state;
    assign busy        = (r_state != S_IDLE);
    assign w_xrem_nx   = r_xrem & (r_xrem - IN_BITS'(1));
    assign w_md        = $signed(mdata_r);
    assign w_prod      = r_h_cur[r_pi] * w_md;
    assign w_term      = r_pmul ? AW'(w_prod) : (AW'(w_md) <<< FW);

    // Lowest remaining set input bit, so W_ih is fetched in ascending k order.
    always_comb begin
        w_k = '0;
        for (int n = IN_BITS - 1; n >= 0; n--)
            if (r_xrem[n]) w_k = KW'(n);
    end

    always_comb begin
        w_rnd = (r_acc + C_HALF) >>> FW;
        case (r_mode)
            2'b01:   begin w_lo = '0;     w_hi = C_ONE;  end
            2'b10:   begin w_lo = C_MIND; w_hi = C_MAXD; end
            default: begin w_lo = -C_ONE; w_hi = C_ONE;  end
        endcase
        if (w_rnd > w_hi)      w_sat = w_hi;
        else if (w_rnd < w_lo) w_sat = w_lo;
        else                   w_sat = w_rnd;
        w_r_act = w_sat[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        i_en    = 1'b0;
        mce     = 1'b0;
        msel    = 3'b100;
        maddr   = '0;
        mdata_w = '0;
        case (r_state)
            S_IDLE:  if (ready) w_next = S_LD_T;
            S_LD_T:  begin
                if (!r_ph) mce = 1'b1;
                else       w_next = (mdata_r[TW-1:0] == '0) ? S_DONE : S_GET_X;
            end
            S_GET_X: begin
                if (!r_ph) i_en = 1'b1;
                else       w_next = S_BIAS;
            end
            S_BIAS:  begin
                mce   = 1'b1;
                msel  = r_ph ? 3'b011 : 3'b001;
                maddr = MAW'(r_j);
                if (r_ph) w_next = (r_xrem != '0) ? S_WIH : (r_t != '0) ? S_WHH : S_WRITE;
            end
            S_WIH:   begin
                mce   = 1'b1;
                msel  = 3'b000;
                maddr = MAW'({r_j, w_k});
                if (w_xrem_nx == '0) w_next = (r_t != '0) ? S_WHH : S_WRITE;
            end
            S_WHH:   begin
                mce   = 1'b1;
                msel  = 3'b010;
                maddr = MAW'({r_j, r_i});
                if (r_i == HW'(HID - 1)) w_next = S_WRITE;
            end
            S_WRITE: begin
                // First cycle drains the last pipelined read; second cycle writes.
                if (r_ph) begin
                    mce     = 1'b1;
                    msel    = 3'b101;
                    maddr   = MAW'({r_t, r_j});
                    mdata_w = w_r_act;
                    if (r_j != HW'(HID - 1))           w_next = S_BIAS;
                    else if (r_t < r_tcnt - TW'(1))    w_next = S_SWAP;
                    else                               w_next = S_DONE;
                end
            end
            S_SWAP:  w_next = S_GET_X;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph   <= 1'b0;
            r_mode <= '0;
            r_tcnt <= '0;
            r_t    <= '0;
            r_j    <= '0;
            r_i    <= '0;
            r_pi   <= '0;
            r_x    <= '0;
            r_xrem <= '0;
            r_pv   <= 1'b0;
            r_pmul <= 1'b0;
            r_acc  <= '0;
            for (int n = 0; n < HID; n++) begin
                r_h_cur[n] <= '0;
                r_h_nxt[n] <= '0;
            end
        end else begin
            r_pv   <= 1'b0;
            r_pmul <= 1'b0;
            r_ph   <= 1'b0;
            if (r_pv) r_acc <= r_acc + w_term;
            case (r_state)
                S_IDLE:  if (ready) begin
                    r_mode <= act_mode;
                    r_t    <= '0;
                    for (int n = 0; n < HID; n++) r_h_cur[n] <= '0;
                end
                S_LD_T:  begin
                    r_ph <= ~r_ph;
                    if (r_ph) r_tcnt <= mdata_r[TW-1:0];
                end
                S_GET_X: begin
                    r_ph <= ~r_ph;
                    if (r_ph) begin
                        r_x <= idata;
                        r_j <= '0;
                    end
                end
                S_BIAS:  begin
                    r_ph <= ~r_ph;
                    r_pv <= 1'b1;
                    r_i  <= '0;
                    if (!r_ph) r_xrem <= r_x;
                end
                S_WIH:   begin
                    r_pv   <= 1'b1;
                    r_xrem <= w_xrem_nx;
                end
                S_WHH:   begin
                    r_pv   <= 1'b1;
                    r_pmul <= 1'b1;
                    r_pi   <= r_i;
                    r_i    <= r_i + HW'(1);
                end
                S_WRITE: begin
                    r_ph <= ~r_ph;
                    if (r_ph) begin
                        r_h_nxt[r_j] <= w_r_act;
                        r_acc        <= '0;
                        if (r_j != HW'(HID - 1)) r_j <= r_j + HW'(1);
                    end
                end
                S_SWAP:  begin
                    for (int n = 0; n < HID; n++) r_h_cur[n] <= r_h_nxt[n];
                    r_t <= r_t + TW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rnn_cell_param.sv
// Directed bench for rnn_cell_param at HID=4, IN_BITS=4: a memory model serves reads,
// and every h write is compared against a hand-computed expected queue.
module tb_rnn_cell_param;
  localparam int HID = 4, IN_BITS = 4, DW = 20, FW = 16, TW = 11, MAW = 13;
  localparam int EW = MAW + DW;

  logic               clk = 1'b0;
  logic               reset, ready;
  logic [1:0]         act_mode;
  logic [IN_BITS-1:0] idata;
  logic [DW-1:0]      mdata_r;
  logic               busy, i_en, mce;
  logic [2:0]         msel;
  logic [MAW-1:0]     maddr;
  logic [DW-1:0]      mdata_w;
  logic [3:0]         dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rnn_cell_param #(.HID(HID), .IN_BITS(IN_BITS), .DW(DW), .FW(FW), .TW(TW), .MAW(MAW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .act_mode(act_mode), .idata(idata),
    .mdata_r(mdata_r), .busy(busy), .i_en(i_en), .mce(mce), .msel(msel),
    .maddr(maddr), .mdata_w(mdata_w), .o_dbg_state(dbg_state)
  );

  // ---------------- memory model and scoreboard ----------------
  logic [DW-1:0]      w_ih [16];
  logic [DW-1:0]      w_hh [16];
  logic [DW-1:0]      b_ih [4];
  logic [DW-1:0]      b_hh [4];
  logic [TW-1:0]      t_val;
  logic [EW-1:0]      exp_q[$];
  logic [IN_BITS-1:0] x_q[$];
  int                 n_cmp = 0, n_bad = 0;
  int                 ien_cnt = 0, trd_cnt = 0, wr_cnt = 0;
  logic               req_v = 1'b0;
  logic [2:0]         req_sel = '0;
  logic [MAW-1:0]     req_addr = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req_v) begin
      case (req_sel)
        3'b000:  mdata_r = w_ih[req_addr[3:0]];
        3'b001:  mdata_r = b_ih[req_addr[1:0]];
        3'b010:  mdata_r = w_hh[req_addr[3:0]];
        3'b011:  mdata_r = b_hh[req_addr[1:0]];
        3'b100:  mdata_r = DW'(t_val);
        default: mdata_r = '0;
      endcase
    end
    req_v    = mce && (msel != 3'b101);
    req_sel  = msel;
    req_addr = maddr;
    if (mce && msel == 3'b100) trd_cnt++;
    if (i_en) begin
      ien_cnt++;
      if (x_q.size() > 0) idata = x_q.pop_front();
      else                idata = '0;
    end
    if (mce && msel == 3'b101) begin
      wr_cnt++;
      if (exp_q.size() == 0) check_val("extra_wr", 64'(exp_q.size()), 64'd1);
      else                   check_val("wr", 64'({maddr, mdata_w}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int n = 0; n < 16; n++) begin
      w_ih[n] = '0;
      w_hh[n] = '0;
    end
    for (int n = 0; n < 4; n++) begin
      b_ih[n] = '0;
      b_hh[n] = '0;
    end
    t_val = '0;
  endtask

  task automatic exp_wr(input int t, input int j, input logic [DW-1:0] d);
    exp_q.push_back({MAW'(t * HID + j), d});
  endtask

  task automatic set_bias(input logic [DW-1:0] b);
    for (int n = 0; n < 4; n++) begin
      b_ih[n] = b;
      b_hh[n] = b;
    end
  endtask

  task automatic run_op(input logic [1:0] mode, input int exp_busy, input int exp_ien, input string tag);
    int n;
    n = 0;
    ien_cnt = 0;
    trd_cnt = 0;
    @(negedge clk);
    act_mode = mode;
    ready    = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check_val({tag, "_busy"}, 64'(n), 64'(exp_busy));
    check_val({tag, "_ien"}, 64'(ien_cnt), 64'(exp_ien));
    check_val({tag, "_trd"}, 64'(trd_cnt), 64'd1);
    check_val({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    x_q.delete();
  endtask

  task automatic setup_recur(input logic [DW-1:0] diag);
    clear_mem();
    t_val = 11'd2;
    for (int j = 0; j < 4; j++) begin
      w_hh[j * 4 + j] = diag;
      w_ih[j * 4]     = 20'h08000;
    end
    x_q.push_back(4'b0001);
    x_q.push_back(4'b0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset    = 1'b1;
    ready    = 1'b0;
    act_mode = 2'b00;
    idata    = '0;
    mdata_r  = '0;
    clear_mem();
    #3;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_ien", 64'(i_en), 64'd0);
    check_val("rst_mce", 64'(mce), 64'd0);
    check_val("rst_msel", 64'(msel), 64'd4);
    check_val("rst_maddr", 64'(maddr), 64'd0);
    check_val("rst_mdata_w", 64'(mdata_w), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // T = 0: one T read, three busy cycles, nothing else.
    run_op(2'b00, 3, 0, "t0");

    // Basic: x=0101, W_ih=0.25 everywhere -> 0.5 per unit.
    clear_mem();
    t_val = 11'd1;
    for (int n2 = 0; n2 < 16; n2++) w_ih[n2] = 20'h04000;
    x_q.push_back(4'b0101);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h08000);
    run_op(2'b00, 29, 1, "basic");

    // Activation modes with x=0, so only the biases contribute.
    clear_mem();
    t_val = 11'd1;
    for (int n2 = 0; n2 < 16; n2++) w_ih[n2] = 20'h04000;
    set_bias(20'h0C000);
    x_q.push_back(4'b0000);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h10000);
    run_op(2'b00, 21, 1, "act00");

    set_bias(20'hF4000);
    x_q.push_back(4'b0000);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h00000);
    run_op(2'b01, 21, 1, "act01");

    set_bias(20'h7FFFF);
    x_q.push_back(4'b0000);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h7FFFF);
    run_op(2'b10, 21, 1, "act10");

    set_bias(20'hF4000);
    x_q.push_back(4'b0000);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'hF0000);
    run_op(2'b11, 21, 1, "act11");

    // Recurrence with identity W_hh carries 0.5 into step 1.
    setup_recur(20'h10000);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h08000);
    for (int j = 0; j < 4; j++) exp_wr(1, j, 20'h08000);
    run_op(2'b00, 60, 2, "recur");

    // Tie case: 0.5 * 2^-16 rounds up to one LSB.
    setup_recur(20'h00001);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h08000);
    for (int j = 0; j < 4; j++) exp_wr(1, j, 20'h00001);
    run_op(2'b00, 60, 2, "round");

    // Abort with reset during t=1, j=2.
    setup_recur(20'h10000);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h08000);
    for (int j = 0; j < 2; j++) exp_wr(1, j, 20'h08000);
    wr_cnt = 0;
    @(negedge clk);
    act_mode = 2'b00;
    ready    = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n = 0;
    while (wr_cnt < 6 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check_val("abort_reach", 64'(wr_cnt), 64'd6);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_mce", 64'(mce), 64'd0);
    check_val("abort_msel", 64'(msel), 64'd4);
    exp_q.delete();
    x_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_val("abort_wr_cnt", 64'(wr_cnt), 64'd6);

    // Restart after abort.
    clear_mem();
    t_val = 11'd1;
    for (int n2 = 0; n2 < 16; n2++) w_ih[n2] = 20'h04000;
    x_q.push_back(4'b0101);
    for (int j = 0; j < 4; j++) exp_wr(0, j, 20'h08000);
    run_op(2'b00, 29, 1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
